// File: rtl/eco_resp_compactor.sv
// rtl/eco_resp_compactor.sv - MISR compactor for the 3-bit ECO cone response stream
module eco_resp_compactor #(
    parameter int              SIG_W = 16,
    parameter int              N_VEC = 32,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       Y,
    input  logic [SIG_W-1:0] EXP_SIG,
    output logic [SIG_W-1:0] SIG,
    output logic [15:0]      CNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [15:0] LAST_CNT = 16'(N_VEC - 1);

    logic [1:0]       state;
    logic             accept;
    logic             last_beat;
    logic [SIG_W-1:0] sig_next;

    // Shift left, fold the outgoing MSB back through POLY, then inject the response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [2:0]       din);
        logic [SIG_W-1:0] shifted;
        shifted = {cur[SIG_W-2:0], 1'b0};
        if (cur[SIG_W-1]) begin
            shifted = shifted ^ POLY;
        end
        return shifted ^ {{(SIG_W-3){1'b0}}, din};
    endfunction

    assign IN_READY  = (state == ST_RUN);
    assign accept    = IN_VALID & IN_READY;
    assign last_beat = accept & (CNT == LAST_CNT);
    assign sig_next  = misr_step(SIG, Y);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            SIG   <= SEED;
            CNT   <= 16'd0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_RUN;
                        SIG   <= SEED;
                        CNT   <= 16'd0;
                        BUSY  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        SIG <= sig_next;
                        CNT <= CNT + 16'd1;
                    end
                    if (last_beat) begin
                        // Verdict uses the signature that includes the final beat.
                        state <= ST_FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (sig_next == EXP_SIG);
                    end
                end
                ST_FIN: begin
                    if (START) begin
                        state <= ST_RUN;
                        SIG   <= SEED;
                        CNT   <= 16'd0;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
                        PASS  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    PASS  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/eco_resp_compactor.md
Name: eco_resp_compactor

Overview:
- Downstream stage of the 5-bit-operand / 3-bit-result ECO test logic cones.
- Consumes the 3-bit Y response stream under a valid/ready handshake and compacts N_VEC responses into a multiple-input signature register (MISR).
- Compares the final signature against an expected golden value and flags PASS/FAIL.
- Lets the pre-ECO and post-ECO netlists be checked for equivalence with one signature compare instead of per-vector checks.

Parameters:
- SIG_W, 16, signature width (≥ 4).
- N_VEC, 32, number of responses compacted per run (1..65535).
- POLY, 16'h1021, MISR feedback polynomial; the x^SIG_W term is implicit.
- SEED, 16'h0000, signature value loaded at START.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset.
- START  input  1  one-cycle pulse; begins a run.
- IN_VALID  input  1  Y is valid this cycle.
- IN_READY  output  1  compactor accepts Y this cycle.
- Y  input  3  response word from the logic cone under test.
- EXP_SIG  input  SIG_W  golden signature; sampled on the DONE transition.
- SIG  output  SIG_W  current signature.
- CNT  output  16  responses accepted in the current run.
- BUSY  output  1  high in RUN.
- DONE  output  1  high in FIN.
- PASS  output  1  valid while DONE: SIG == EXP_SIG.

Behaviour:
- Reset (RST_N low at a CLK edge), which overrides everything including mid-run:
  - state = IDLE, SIG = SEED, CNT = 0.
  - BUSY = 0, DONE = 0, PASS = 0, IN_READY = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - IN_READY = 0.
  - START = 1 -> RUN next cycle, with SIG = SEED, CNT = 0.
- RUN:
  - IN_READY = 1 combinationally, BUSY = 1.
  - A beat is accepted when IN_VALID & IN_READY at a CLK edge.
  - On each accepted beat: SIG <= ({SIG[SIG_W-2:0],1'b0} ^ (SIG[SIG_W-1] ? POLY : 0)) ^ zero-extend(Y), and CNT <= CNT + 1.
  - No beat: SIG and CNT hold.
  - The beat that makes CNT reach N_VEC also moves the state to FIN. That beat's Y is included in SIG.
  - START during RUN is ignored.
- FIN:
  - DONE = 1, IN_READY = 0, BUSY = 0; SIG and CNT frozen.
  - PASS = (SIG == EXP_SIG), registered on the RUN->FIN edge using EXP_SIG from that edge's post-update SIG. PASS is stable thereafter.
  - START = 1 -> RUN with SIG = SEED, CNT = 0; DONE and PASS clear next cycle.
- Latency:
  - SIG reflects a beat one cycle after acceptance.
  - DONE rises one cycle after the final accepted beat.
- IN_VALID while IN_READY = 0 (IDLE/FIN): the beat is dropped, SIG unaffected; the upstream holds the data.
- Y X/unknown is not sanitised; the upstream guarantees known values when IN_VALID is high.
- CNT is 16 bits and never wraps; N_VEC ≤ 65535 is guaranteed by the parameter range.
- Outputs are registered except IN_READY, which is decoded from state.

Test Plan:
- Reset/idle:
  - Stimulus: assert RST_N = 0 for 2 cycles, then IN_VALID = 1 with Y = 3'b111 while IDLE.
  - Required: SIG = 16'h0000, CNT = 0, IN_READY = 0, DONE = 0, SIG unchanged.
- Basic run (N_VEC = 2, SEED = 0):
  - Stimulus: START, then Y = 3'b101 followed by Y = 3'b011, IN_VALID continuous; EXP_SIG = 16'h0009.
  - Required: SIG = 16'h0005 after beat 1 and 16'h0009 after beat 2; DONE = 1 and PASS = 1 one cycle after beat 2.
- Feedback tap:
  - Stimulus: SEED = 16'h8000, N_VEC = 1, START, Y = 3'b000.
  - Required: SIG = 16'h1021, DONE = 1.
  - Stimulus: rerun with EXP_SIG = 16'h1020.
  - Required: PASS = 0.
- Valid gaps:
  - Stimulus: N_VEC = 32, IN_VALID toggles randomly.
  - Required: CNT increments only on handshakes; final SIG matches the reference model; DONE after exactly 32 beats.
- Mid-run reset:
  - Stimulus: RST_N = 0 after 10 beats.
  - Required: next cycle IDLE, SIG = SEED, CNT = 0, BUSY = 0.
  - Stimulus: a new START.
  - Required: a fresh run gives the same SIG as an uninterrupted run.
- Restart from FIN:
  - Stimulus: START while DONE = 1; START pulsed again during RUN.
  - Required: DONE/PASS clear, CNT = 0, SIG = SEED next cycle; the second START has no effect.
